instr_mem_loader: RTL

Byte-serial program loader: the write side of the instruction memory. It accepts a length-prefixed little-endian byte stream, assembles 32-bit instruction words and issues one-cycle word writes to the instruction memory's write port. It holds the core in reset until a load completes cleanly. It sits between a host byte source (UART receiver or testbench) and the instruction memory.

---
 rtl/instr_loader_pkg.sv | 40 ++++
 rtl/instr_mem_loader_word_assembler.sv | 34 +++
 rtl/instr_mem_loader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the byte-serial instruction memory loader.
// The CKSUM state only exists when INSTR_LOADER_CHECKSUM_EN is defined.
package instr_loader_pkg;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN0,
      ST_LEN1,
      ST_DATA,
`ifdef INSTR_LOADER_CHECKSUM_EN
      ST_CKSUM,
`endif
      ST_DONE,
      ST_ERR
   } state_t;

   // Where a load goes once the payload is complete (or empty).
`ifdef INSTR_LOADER_CHECKSUM_EN
   localparam state_t ST_AFTER_DATA = ST_CKSUM;
`else
   localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

   function automatic logic accepting(input state_t s);
      logic r;
      r = 1'b0;
      case (s)
         ST_LEN0, ST_LEN1, ST_DATA: r = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
         ST_CKSUM:                  r = 1'b1;
`endif
         default:                   r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Collects four little-endian bytes into a 32-bit word; word_valid pulses
// combinationally with the fourth byte so the caller can register the write.
module word_assembler
   import instr_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  cnt;
   logic [23:0] shreg;

   // The top byte never needs storing: it arrives together with word_valid.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt   <= '0;
         shreg <= '0;
      end else if (byte_valid) begin
         cnt   <= cnt + 2'd1;
         shreg <= {byte_in, shreg[23:8]};
      end
   end

   always_comb begin
      word_valid = byte_valid && (cnt == 2'(BYTES_PER_WORD - 1));
      word       = {byte_in, shreg};
   end

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-serial program loader: length-prefixed little-endian stream -> one-cycle
// 32-bit word writes; holds the core in reset until a clean load. INSTR_LOADER_CHECKSUM_EN adds an XOR checksum byte.
module instr_mem_loader
   import instr_loader_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   output logic        cpu_hold,
   output logic        done,
   output logic        err
);

   // One extra bit so a full-capacity load can count to 2^ADDR_W without wrapping.
   localparam int IDX_W = ADDR_W + 1;

   state_t           state, state_nxt;
   logic [7:0]       len_lo;
   logic [15:0]      len;
   logic [15:0]      hdr_n;
   logic [IDX_W-1:0] idx;
   logic             start, accept, data_acc, too_big, last_word;
   logic             word_valid;
   logic [31:0]      word;

`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [7:0] cksum;

   always_ff @(posedge clk) begin
      if (rst || start)
         cksum <= '0;
      else if (data_acc)
         cksum <= cksum ^ in_data;
   end
`endif

   word_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .clear      (start),
      .byte_valid (data_acc),
      .byte_in    (in_data),
      .word_valid (word_valid),
      .word       (word)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      start     = load_start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
      accept    = in_valid && in_ready;
      data_acc  = accept && (state == ST_DATA);
      hdr_n     = {in_data, len_lo};
      too_big   = {17'd0, hdr_n} > (33'd1 << ADDR_W);
      last_word = (32'(idx) + 32'd1) == 32'(len);
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE, ST_ERR:
            if (start) state_nxt = ST_LEN0;
         ST_LEN0:
            if (accept) state_nxt = ST_LEN1;
         ST_LEN1:
            if (accept) begin
               if (too_big)
                  state_nxt = ST_ERR;
               else if (hdr_n == 16'd0)
                  state_nxt = ST_AFTER_DATA;
               else
                  state_nxt = ST_DATA;
            end
         ST_DATA:
            if (word_valid && last_word) state_nxt = ST_AFTER_DATA;
`ifdef INSTR_LOADER_CHECKSUM_EN
         ST_CKSUM:
            if (accept) state_nxt = (in_data == cksum) ? ST_DONE : ST_ERR;
`endif
         default:
            state_nxt = ST_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they move with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         cpu_hold <= 1'b1;
      end else begin
         in_ready <= accepting(state_nxt);
         done     <= (state_nxt == ST_DONE);
         err      <= (state_nxt == ST_ERR);
         cpu_hold <= (state_nxt != ST_DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len_lo   <= '0;
         len      <= '0;
         idx      <= '0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_wd   <= '0;
      end else begin
         mem_we <= 1'b0;
         if (start) begin
            len <= '0;
            idx <= '0;
         end
         if (accept && state == ST_LEN0)
            len_lo <= in_data;
         if (accept && state == ST_LEN1)
            len <= hdr_n;
         if (word_valid) begin
            mem_we   <= 1'b1;
            mem_addr <= 32'(idx[ADDR_W-1:0]) << 2;
            mem_wd   <= word;
            idx      <= idx + 1'b1;
         end
      end
   end

endmodule
